// File: rtl/axi4lite_pkg.sv
// Shared AXI4-Lite definitions: response codes, protection width and the
// read-channel state encoding used by the SRAM slave.
package axi4lite_pkg;

  localparam int AXI4L_RESP_BITS = 2;
  localparam int PROT_BITS       = 3;

  typedef enum logic [AXI4L_RESP_BITS-1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } axi4l_resp_e;

  typedef enum logic [0:0] {
    R_IDLE = 1'b0,
    R_RESP = 1'b1
  } r_state_t;

endpackage

// File: rtl/axi4lite_sram_bank.sv
// One-read/one-write synchronous word array with per-byte write enables and a
// registered read port; a same-edge read of a word being written returns old data.
module axi4lite_sram_bank #(
  parameter int  DATA_BITS   = 64,
  parameter int  DEPTH_WORDS = 1024,
  localparam int IDX_BITS    = $clog2(DEPTH_WORDS),
  localparam int STRB_BITS   = DATA_BITS / 8
) (
  input  logic                 clk,
  input  logic                 rd_en,
  input  logic [IDX_BITS-1:0]  rd_idx,
  output logic [DATA_BITS-1:0] rd_data,
  input  logic                 wr_en,
  input  logic [IDX_BITS-1:0]  wr_idx,
  input  logic [DATA_BITS-1:0] wr_data,
  input  logic [STRB_BITS-1:0] wr_strb
);

  logic [DATA_BITS-1:0] mem [DEPTH_WORDS];
  logic [DATA_BITS-1:0] rd_data_d, rd_data_q;

  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) rd_data_d = mem[rd_idx];
  end

  // NOTE: the array and its read register carry no reset; a RAM macro cannot be
  // cleared in one cycle, and the slave masks read data with its own valid flag.
  always_ff @(posedge clk) begin
    rd_data_q <= rd_data_d;
    for (int i = 0; i < STRB_BITS; i++) begin
      if (wr_en && wr_strb[i]) mem[wr_idx][i*8 +: 8] <= wr_data[i*8 +: 8];
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/axi4lite_sram_slave.sv
// AXI4-Lite slave memory over a fixed address window; out-of-window accesses
// answer DECERR. Write side uses one holding slot per channel, read side a 2-state FSM.
module axi4lite_sram_slave
  import axi4lite_pkg::*;
#(
  parameter int                   ADDR_BITS   = 32,
  parameter int                   DATA_BITS   = 64,
  parameter int                   DEPTH_WORDS = 1024,
  parameter logic [ADDR_BITS-1:0] BASE_ADDR   = ADDR_BITS'(32'h8000_0000)
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       s_axi4lite_aw_valid,
  output logic                       s_axi4lite_aw_ready,
  input  logic [ADDR_BITS-1:0]       s_axi4lite_aw_addr,
  input  logic [PROT_BITS-1:0]       s_axi4lite_aw_prot,
  input  logic                       s_axi4lite_w_valid,
  output logic                       s_axi4lite_w_ready,
  input  logic [DATA_BITS-1:0]       s_axi4lite_w_data,
  input  logic [DATA_BITS/8-1:0]     s_axi4lite_w_strb,
  output logic                       s_axi4lite_b_valid,
  input  logic                       s_axi4lite_b_ready,
  output logic [AXI4L_RESP_BITS-1:0] s_axi4lite_b_resp,
  input  logic                       s_axi4lite_ar_valid,
  output logic                       s_axi4lite_ar_ready,
  input  logic [ADDR_BITS-1:0]       s_axi4lite_ar_addr,
  input  logic [PROT_BITS-1:0]       s_axi4lite_ar_prot,
  output logic                       s_axi4lite_r_valid,
  input  logic                       s_axi4lite_r_ready,
  output logic [DATA_BITS-1:0]       s_axi4lite_r_data,
  output logic [AXI4L_RESP_BITS-1:0] s_axi4lite_r_resp
);

  localparam int STRB_BITS = DATA_BITS / 8;
  localparam int OFF_BITS  = $clog2(STRB_BITS);
  localparam int IDX_BITS  = $clog2(DEPTH_WORDS);
  localparam logic [ADDR_BITS:0] WIN_END =
    {1'b0, BASE_ADDR} + (ADDR_BITS+1)'(DEPTH_WORDS * STRB_BITS);

  function automatic logic addr_in_range(input logic [ADDR_BITS-1:0] addr);
    return (addr >= BASE_ADDR) && ({1'b0, addr} < WIN_END);
  endfunction

  // Byte-offset bits drop out of the shift, so unaligned addresses are accepted.
  function automatic logic [IDX_BITS-1:0] addr_index(input logic [ADDR_BITS-1:0] addr);
    return IDX_BITS'((addr - BASE_ADDR) >> OFF_BITS);
  endfunction

  logic                 live_d, live_q;
  logic                 aw_held_d, aw_held_q;
  logic [ADDR_BITS-1:0] aw_addr_d, aw_addr_q;
  logic                 w_held_d, w_held_q;
  logic [DATA_BITS-1:0] w_data_d, w_data_q;
  logic [STRB_BITS-1:0] w_strb_d, w_strb_q;
  logic                 b_valid_d, b_valid_q;
  axi4l_resp_e          b_resp_d, b_resp_q;
  r_state_t             r_state_d, r_state_q;
  axi4l_resp_e          r_resp_d, r_resp_q;
  logic                 r_hit_d, r_hit_q;

  logic                 aw_hs, w_hs, ar_hs, commit, wr_hit, rd_hit;
  logic [DATA_BITS-1:0] bank_rd_data;
  logic                 unused_prot;

  assign s_axi4lite_aw_ready = live_q && !aw_held_q;
  assign s_axi4lite_w_ready  = live_q && !w_held_q;
  assign s_axi4lite_ar_ready = live_q && (r_state_q == R_IDLE);

  assign aw_hs  = s_axi4lite_aw_valid && s_axi4lite_aw_ready;
  assign w_hs   = s_axi4lite_w_valid  && s_axi4lite_w_ready;
  assign ar_hs  = s_axi4lite_ar_valid && s_axi4lite_ar_ready;
  // A new commit may only replace a response that is leaving this cycle.
  assign commit = aw_held_q && w_held_q && (!b_valid_q || s_axi4lite_b_ready);
  assign wr_hit = addr_in_range(aw_addr_q);
  assign rd_hit = addr_in_range(s_axi4lite_ar_addr);

  always_comb begin
    live_d    = 1'b1;
    aw_held_d = aw_held_q;
    aw_addr_d = aw_addr_q;
    w_held_d  = w_held_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    b_valid_d = b_valid_q;
    b_resp_d  = b_resp_q;

    if (aw_hs) begin
      aw_held_d = 1'b1;
      aw_addr_d = s_axi4lite_aw_addr;
    end
    if (w_hs) begin
      w_held_d = 1'b1;
      w_data_d = s_axi4lite_w_data;
      w_strb_d = s_axi4lite_w_strb;
    end
    if (commit) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      b_valid_d = 1'b1;
      b_resp_d  = wr_hit ? OKAY : DECERR;
    end else if (s_axi4lite_b_ready) begin
      b_valid_d = 1'b0;
    end
  end

  always_comb begin
    r_state_d = r_state_q;
    r_resp_d  = r_resp_q;
    r_hit_d   = r_hit_q;
    case (r_state_q)
      R_IDLE: begin
        if (ar_hs) begin
          r_state_d = R_RESP;
          r_hit_d   = rd_hit;
          r_resp_d  = rd_hit ? OKAY : DECERR;
        end
      end
      R_RESP: begin
        if (s_axi4lite_r_ready) r_state_d = R_IDLE;
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  // NOTE: reset is sampled on the clock edge only; every flop here, including
  // live_q that gates the readys, clears together so outputs read 0 after it.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      live_q    <= 1'b0;
      aw_held_q <= 1'b0;
      aw_addr_q <= '0;
      w_held_q  <= 1'b0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      b_valid_q <= 1'b0;
      b_resp_q  <= OKAY;
      r_state_q <= R_IDLE;
      r_resp_q  <= OKAY;
      r_hit_q   <= 1'b0;
    end else begin
      live_q    <= live_d;
      aw_held_q <= aw_held_d;
      aw_addr_q <= aw_addr_d;
      w_held_q  <= w_held_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      b_valid_q <= b_valid_d;
      b_resp_q  <= b_resp_d;
      r_state_q <= r_state_d;
      r_resp_q  <= r_resp_d;
      r_hit_q   <= r_hit_d;
    end
  end

  axi4lite_sram_bank #(
    .DATA_BITS   (DATA_BITS),
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_bank (
    .clk     (clk),
    .rd_en   (ar_hs),
    .rd_idx  (addr_index(s_axi4lite_ar_addr)),
    .rd_data (bank_rd_data),
    .wr_en   (commit && wr_hit),
    .wr_idx  (addr_index(aw_addr_q)),
    .wr_data (w_data_q),
    .wr_strb (w_strb_q)
  );

  assign s_axi4lite_b_valid = b_valid_q;
  assign s_axi4lite_b_resp  = b_resp_q;
  assign s_axi4lite_r_valid = (r_state_q == R_RESP);
  assign s_axi4lite_r_resp  = r_resp_q;
  assign s_axi4lite_r_data  = ((r_state_q == R_RESP) && r_hit_q) ? bank_rd_data : '0;

  assign unused_prot = ^{s_axi4lite_aw_prot, s_axi4lite_ar_prot};

endmodule

// File: doc/axi4lite_sram_slave.md
Name: axi4lite_sram_slave

Overview:
AXI4-Lite slave memory that terminates the master port of the AXI4-to-AXI4-Lite bridge. It is the external-memory endpoint in the bridge test harness and in small SoC configurations. It supports independent read and write channels, byte strobes and a fixed address window. Accesses outside the window return DECERR.

Parameters:
ADDR_BITS, 32, AXI4-Lite address width
DATA_BITS, 64, data width; must be 32 or 64
DEPTH_WORDS, 1024, number of DATA_BITS-wide words; power of 2
BASE_ADDR, 32'h8000_0000, first byte address of the window; aligned to DEPTH_WORDS*DATA_BITS/8

Ports:
clk  in  1  clock
rstn  in  1  reset, synchronous, active-low
s_axi4lite_aw_valid  in  1  write address valid
s_axi4lite_aw_ready  out  1  write address ready
s_axi4lite_aw_addr  in  ADDR_BITS  write byte address
s_axi4lite_aw_prot  in  3  protection (ignored)
s_axi4lite_w_valid  in  1  write data valid
s_axi4lite_w_ready  out  1  write data ready
s_axi4lite_w_data  in  DATA_BITS  write data
s_axi4lite_w_strb  in  DATA_BITS/8  byte enables
s_axi4lite_b_valid  out  1  write response valid
s_axi4lite_b_ready  in  1  write response ready
s_axi4lite_b_resp  out  2  write response code
s_axi4lite_ar_valid  in  1  read address valid
s_axi4lite_ar_ready  out  1  read address ready
s_axi4lite_ar_addr  in  ADDR_BITS  read byte address
s_axi4lite_ar_prot  in  3  protection (ignored)
s_axi4lite_r_valid  out  1  read data valid
s_axi4lite_r_ready  in  1  read data ready
s_axi4lite_r_data  out  DATA_BITS  read data
s_axi4lite_r_resp  out  2  read response code

Behaviour:
- Reset (rstn=0 at posedge clk) drives every output to 0: all readys, b_valid, r_valid, b_resp, r_data, r_resp. It clears all holding slots. Memory contents are not reset.
- Reset mid-transaction silently drops pending AW, W, B and R. In the first cycle after reset, aw_ready, w_ready and ar_ready are 1.
- Address decode: in_range = (addr >= BASE_ADDR) && (addr < BASE_ADDR + DEPTH_WORDS*DATA_BITS/8).
- Word index = (addr - BASE_ADDR) >> log2(DATA_BITS/8). Low byte-offset bits are ignored (no alignment error).
- Write path, AW and W:
  - Each channel has a one-entry holding slot. aw_ready = !aw_held; w_ready = !w_held.
  - The two channels are accepted independently, in either order or in the same cycle.
- Write commit occurs on a cycle where both slots are full and (b_valid=0 or b_ready=1).
  - If in_range, bytes with strb[i]=1 are written; other bytes keep their old value.
  - If out of range, nothing is written.
  - Both slots are cleared at the same edge. b_valid=1 on the next cycle with b_resp = OKAY (2'b00) or DECERR (2'b11).
- A write whose AW and W handshake in the same cycle gives b_valid 2 cycles after that handshake edge.
- b_valid holds with a stable b_resp until b_ready. New AW/W may be accepted while B is pending, but at most one commit is outstanding.
- Read path FSM:
  - R_IDLE: ar_ready=1. On ar_valid&&ar_ready, the array is read and the FSM moves to R_RESP. Next cycle: r_valid=1 and r_data = word, or 0 if out of range. r_resp = OKAY or DECERR.
  - R_RESP: ar_ready=0. r_data and r_resp stay stable until r_ready. On r_valid&&r_ready, return to R_IDLE; ar_ready is 1 in the following cycle.
  - Read latency: 1 cycle from the AR handshake. Maximum throughput: 1 read per 2 cycles.
- Simultaneous read and write commit to the same word in the same cycle: the read returns pre-write data (read-before-write).
- Read and write channels never stall each other.
- prot is ignored. EXOKAY and SLVERR are never produced.

Decomposition:
- Package axi4lite_pkg holds:
  - AXI4L_RESP_BITS=2
  - resp enum: OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11
  - PROT_BITS=3
  - read FSM state typedef r_state_t {R_IDLE, R_RESP}
- One sub-module: axi4lite_sram_bank, a 1-read/1-write synchronous array with per-byte write enable and registered read data. It has no reset.

Test Plan:
- Write 0x8000_0008, data 64'hDEAD_BEEF_0123_4567, strb 8'hFF, AW and W in the same cycle, b_ready=1 → b_valid 2 cycles later, b_resp=2'b00. Then read 0x8000_0008 → r_valid 1 cycle after AR, r_data=64'hDEAD_BEEF_0123_4567, r_resp=2'b00.
- Partial strobe: write 0x8000_0008, data 64'h1111_1111_1111_1111, strb 8'h0F → readback 64'hDEAD_BEEF_1111_1111.
- W presented 3 cycles before AW; b_ready held 0 for 5 cycles → w_ready=0 after W is taken. b_valid and b_resp stay stable until b_ready. The next AW/W pair is accepted but not committed until B completes.
- Out-of-range write at 0x7FFF_FFF8 and read at BASE_ADDR+0x2000 (DEPTH=1024, 64-bit) → b_resp=2'b11, r_resp=2'b11, r_data=0, memory unchanged.
- Read and write commit to 0x8000_0010 in the same cycle (old value 0, new value 64'h5A) → r_data=0; a subsequent read returns 64'h5A.
- Assert rstn=0 for 1 cycle while r_valid=1 and aw_held=1 → next cycle all outputs are 0. The cycle after that, aw_ready/w_ready/ar_ready=1 with no spurious b_valid or r_valid.
